// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: write-port modify modes and default data width.
// Pure declarations; no latency or flow control.
// Imported by the register file and its next-value logic.
package cpu_pkg;

    localparam int CPU_WIDTH = 16;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;
    localparam logic [1:0] MODE_CLR  = 2'b11;

endpackage

// File: rtl/regfile_next.sv
// Next-value computation for the register file write port (load/inc/dec/clear).
// Purely combinational, zero latency.
// No flow control; result is consumed by the commit path and the read bypass.
module regfile_next
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic [WIDTH-1:0] oldVal,
    input  logic [1:0]       wmode,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] nv,
    output logic             wrapNext
);

    always_comb begin
        nv       = oldVal;
        wrapNext = 1'b0;
        case (wmode)
            MODE_LOAD: nv = wdata;
            MODE_INC: begin
                nv       = oldVal + WIDTH'(1);
                wrapNext = (oldVal == '1);
            end
            MODE_DEC: begin
                nv       = oldVal - WIDTH'(1);
                wrapNext = (oldVal == '0);
            end
            MODE_CLR: nv = '0;
            default:  nv = oldVal;
        endcase
    end

endmodule

// File: rtl/cpu_regfile.sv
// DEPTH x WIDTH register file: one modify-in-place write port, two read ports.
// Reads and wrap flag are registered, 1-cycle latency; same-cycle writes bypass to reads.
// No backpressure: a write or read is accepted every cycle.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int WIDTH   = CPU_WIDTH,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        wmode,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [DEPTH-1:0]  valid,
    output logic              wrap
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] oldVal;
    logic [WIDTH-1:0] nv;
    logic             wrapNext;
    logic             wrEn;
    logic [WIDTH-1:0] rdNextA;
    logic [WIDTH-1:0] rdNextB;

    assign oldVal = regs[waddr];

    // With ZERO_R0 the hard-wired zero register swallows writes entirely.
    assign wrEn = we && !(ZERO_R0 && (waddr == '0));

    regfile_next #(.WIDTH(WIDTH)) uNext (
        .oldVal   (oldVal),
        .wmode    (wmode),
        .wdata    (wdata),
        .nv       (nv),
        .wrapNext (wrapNext)
    );

    always_comb begin
        rdNextA = regs[raddr_a];
        if (ZERO_R0 && (raddr_a == '0)) begin
            rdNextA = '0;
        end else if (wrEn && (raddr_a == waddr)) begin
            rdNextA = nv;
        end
    end

    always_comb begin
        rdNextB = regs[raddr_b];
        if (ZERO_R0 && (raddr_b == '0)) begin
            rdNextB = '0;
        end else if (wrEn && (raddr_b == waddr)) begin
            rdNextB = nv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            valid   <= '0;
            rdata_a <= '0;
            rdata_b <= '0;
            wrap    <= 1'b0;
        end else begin
            if (wrEn) begin
                regs[waddr]  <= nv;
                valid[waddr] <= 1'b1;
            end
            rdata_a <= rdNextA;
            rdata_b <= rdNextB;
            wrap    <= wrEn && wrapNext;
        end
    end

endmodule

// File: doc/cpu_regfile.md
Name: cpu_regfile

Overview:
- Parametrised multi-register storage block for the 16-bit CPU datapath.
- Generalises the single accumulator-style register into DEPTH registers of WIDTH bits.
- One write port supports in-place modes: load, increment, decrement and clear.
- Two registered read ports with write-through bypass; per-register valid bitmap; wrap flag feeding the control unit.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers (power of two, ≥2).
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).
- ZERO_R0, 0, when 1 register 0 reads as 0 and ignores writes.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write/modify enable.
- wmode  input  2  00 LOAD, 01 INC, 10 DEC, 11 CLR.
- waddr  input  ADDR_W  target register.
- wdata  input  WIDTH  load data (used only in LOAD).
- raddr_a  input  ADDR_W  read port A address.
- raddr_b  input  ADDR_W  read port B address.
- rdata_a  output  WIDTH  registered read data A.
- rdata_b  output  WIDTH  registered read data B.
- valid  output  DEPTH  bit i = register i written since reset.
- wrap  output  1  one-cycle pulse on INC/DEC wrap.

Behaviour:
- Reset (rst=1 at edge): all registers 0, rdata_a/b 0, valid all 0, wrap 0. rst dominates we in the same cycle. Reset mid-sequence discards any in-flight modify.
- Hold: we=0 leaves every register unchanged; rdata still updates from raddr.
- Write (we=1), next value nv of reg[waddr], committed at the edge:
  - LOAD: nv = wdata.
  - INC: nv = reg+1 modulo 2^WIDTH.
  - DEC: nv = reg−1 modulo 2^WIDTH.
  - CLR: nv = 0.
- valid[waddr] set to 1 on any write, including CLR. It is cleared only by rst.
- wrap is registered and asserted the cycle after the edge:
  - INC with old value all-ones.
  - DEC with old value 0.
  - Otherwise 0. Never asserted for LOAD or CLR.
- Read latency is 1 cycle: rdata_x at edge N+1 reflects raddr_x sampled at edge N.
- Bypass: if we=1 and raddr_x==waddr in the same cycle, rdata_x takes nv, never the stale value. Ports A and B bypass independently, and both may read the same address.
- ZERO_R0=1:
  - Writes to address 0 are dropped; valid[0] stays 0 and wrap stays 0.
  - Reads of address 0 return 0, including under bypass.
- No back-to-back hazard: consecutive INCs to the same address in consecutive cycles accumulate (+1 per cycle).
- Out-of-range addresses cannot occur (DEPTH is a power of two).

Decomposition:
- Shared package cpu_pkg:
  - mode constants MODE_LOAD=2'b00, MODE_INC=2'b01, MODE_DEC=2'b10, MODE_CLR=2'b11.
  - WIDTH default constant CPU_WIDTH=16.
- Sub-module regfile_next (combinational):
  - inputs: old value, wmode, wdata.
  - outputs: nv, wrap_next.
  - Instantiated once on the write path; its nv output is shared by the bypass muxes.
- Storage array, valid vector, read registers and wrap register live in cpu_regfile.

Test Plan:
- Reset then read all addresses → rdata_a/b=0x0000, valid=8'h00, wrap=0.
- LOAD r3=0x00FE, then next cycle read A=3 → rdata_a=0x00FE one cycle later; valid=8'h08.
- LOAD r5=0xFFFF, then INC r5 → r5=0x0000 and wrap=1 for exactly one cycle. Then DEC r5 → r5=0xFFFF and wrap=1 again.
- Same-cycle bypass: raddr_a=raddr_b=2 while LOAD r2=0x0FE6 (old value 0x1111) → both rdata=0x0FE6 next cycle. Repeat with INC → 0x0FE7.
- ZERO_R0=1 instance: LOAD r0=0xABCD with raddr_a=0 → rdata_a=0x0000 and valid[0]=0.
- Four consecutive INCs on r1 from 0x0007, with rst asserted on the third → r1=0x0000 and valid=0 after reset. The fourth INC yields r1=0x0001.
